// File: rtl/ifid_queue.sv
// ifid_queue: circular buffer between instruction fetch and decode.
// It holds up to DEPTH {pc, inst} entries. Occupancy comes from a
// registered count, so fetch_ready_out never depends on dec_ready_in
// within the same cycle. Head outputs read as zero while the queue is empty.
module ifid_queue #(
    parameter int DEPTH = 2
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic                     flush_in,
    input  logic                     fetch_valid_in,
    output logic                     fetch_ready_out,
    input  logic [31:0]              fetch_pc_in,
    input  logic [31:0]              fetch_inst_in,
    output logic                     dec_valid_out,
    input  logic                     dec_ready_in,
    output logic [31:0]              dec_pc_out,
    output logic [4:0]               dec_opcode_out,
    output logic [24:0]              dec_inst_out,
    output logic                     dec_illegal_out,
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic          enq;
    logic          deq;
    logic [31:0]   head_inst;

    // Handshake qualification; flush suppresses both transfers.
    always_comb begin
        fetch_ready_out = (count < CW'(DEPTH));
        dec_valid_out   = (count != '0);
        enq             = fetch_valid_in && fetch_ready_out && !flush_in;
        deq             = dec_valid_out && dec_ready_in && !flush_in;
    end

    // Pointer and occupancy state. Flush has priority over both transfers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush_in) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            // Pointers are PW bits wide and DEPTH is a power of two, so
            // DEPTH-1 wraps to 0 by itself.
            if (enq) wptr <= wptr + 1'b1;
            if (deq) rptr <= rptr + 1'b1;
            if (enq && !deq)      count <= count + 1'b1;
            else if (deq && !enq) count <= count - 1'b1;
        end
    end

    // Entry storage, written on enqueue.
    // NOTE: the storage array has no reset; stale entries are hidden by the zero-when-empty output mux.
    always_ff @(posedge clock_in) begin
        if (enq) begin
            pc_mem[wptr]   <= fetch_pc_in;
            inst_mem[wptr] <= fetch_inst_in;
        end
    end

    // Head presentation: all decode fields read as zero when the queue is empty.
    // NOTE: each output gets a default first, so this block cannot infer a latch.
    always_comb begin
        head_inst       = '0;
        dec_pc_out      = '0;
        dec_opcode_out  = '0;
        dec_inst_out    = '0;
        dec_illegal_out = 1'b0;
        if (dec_valid_out) begin
            head_inst       = inst_mem[rptr];
            dec_pc_out      = pc_mem[rptr];
            dec_opcode_out  = head_inst[6:2];
            dec_inst_out    = head_inst[31:7];
            dec_illegal_out = (head_inst[1:0] != 2'b11);
        end
    end

    assign count_out = count;

endmodule

// File: tb/tb_ifid_queue.sv
// tb_ifid_queue: directed and randomized checks of ifid_queue against a
// queue-based reference model of fetch entries.
module tb_ifid_queue;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock_in;
    logic          reset_in;
    logic          flush_in;
    logic          fetch_valid_in;
    logic          fetch_ready_out;
    logic [31:0]   fetch_pc_in;
    logic [31:0]   fetch_inst_in;
    logic          dec_valid_out;
    logic          dec_ready_in;
    logic [31:0]   dec_pc_out;
    logic [4:0]    dec_opcode_out;
    logic [24:0]   dec_inst_out;
    logic          dec_illegal_out;
    logic [CW-1:0] count_out;

    int errors = 0;
    int checks = 0;

    // Each model entry is {pc, inst}.
    logic [63:0] model_q[$];
    int          drained;

    ifid_queue #(.DEPTH(DEPTH)) dut (
        .clock_in        (clock_in),
        .reset_in        (reset_in),
        .flush_in        (flush_in),
        .fetch_valid_in  (fetch_valid_in),
        .fetch_ready_out (fetch_ready_out),
        .fetch_pc_in     (fetch_pc_in),
        .fetch_inst_in   (fetch_inst_in),
        .dec_valid_out   (dec_valid_out),
        .dec_ready_in    (dec_ready_in),
        .dec_pc_out      (dec_pc_out),
        .dec_opcode_out  (dec_opcode_out),
        .dec_inst_out    (dec_inst_out),
        .dec_illegal_out (dec_illegal_out),
        .count_out       (count_out)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output with what the model queue says it should be.
    task automatic check_model(input string tag);
        logic [31:0] hpc;
        logic [31:0] hinst;
        hpc   = '0;
        hinst = '0;
        if (model_q.size() != 0) begin
            hpc   = model_q[0][63:32];
            hinst = model_q[0][31:0];
        end
        check({tag, ".count"}, 32'(count_out), 32'(model_q.size()));
        check({tag, ".valid"}, 32'(dec_valid_out), 32'(model_q.size() != 0));
        check({tag, ".ready"}, 32'(fetch_ready_out), 32'(model_q.size() < DEPTH));
        check({tag, ".pc"}, dec_pc_out, hpc);
        check({tag, ".opcode"}, 32'(dec_opcode_out), (model_q.size() != 0) ? 32'(hinst[6:2]) : 32'd0);
        check({tag, ".inst"}, 32'(dec_inst_out), (model_q.size() != 0) ? 32'(hinst[31:7]) : 32'd0);
        check({tag, ".illegal"}, 32'(dec_illegal_out),
              (model_q.size() != 0) ? 32'(hinst[1:0] != 2'b11) : 32'd0);
    endtask

    // Drive one cycle of inputs, let the edge happen, update the model, then check.
    task automatic step(input string tag, input logic fv, input logic [31:0] pc,
                        input logic [31:0] inst, input logic dr, input logic fl);
        bit do_enq;
        bit do_deq;
        fetch_valid_in = fv;
        fetch_pc_in    = pc;
        fetch_inst_in  = inst;
        dec_ready_in   = dr;
        flush_in       = fl;
        do_enq = fv && (model_q.size() < DEPTH) && !fl;
        do_deq = dr && (model_q.size() != 0) && !fl;
        @(posedge clock_in);
        #1;
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_deq) begin
                void'(model_q.pop_front());
                drained++;
            end
            if (do_enq) model_q.push_back({pc, inst});
        end
        check_model(tag);
    endtask

    initial begin
        int sent;
        int cycles;
        logic [31:0] rinst;
        drained        = 0;
        reset_in       = 1'b1;
        flush_in       = 1'b0;
        fetch_valid_in = 1'b0;
        fetch_pc_in    = '0;
        fetch_inst_in  = '0;
        dec_ready_in   = 1'b0;

        // Reset state.
        repeat (2) @(posedge clock_in);
        #1;
        check_model("reset");
        @(negedge clock_in);
        reset_in = 1'b0;

        // Single pass with known decode fields, which must appear one cycle after the enqueue.
        step("single", 1'b1, 32'h100, 32'h0050_0093, 1'b0, 1'b0);
        check("single.opc_const", 32'(dec_opcode_out), 32'b00100);
        check("single.inst_const", 32'(dec_inst_out), 32'h000A001);
        check("single.ill_const", 32'(dec_illegal_out), 32'd0);
        step("single.drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Fill and backpressure: the third instruction is held by fetch.
        step("fill1", 1'b1, 32'h200, 32'h0000_0013, 1'b0, 1'b0);
        step("fill2", 1'b1, 32'h204, 32'h0010_0113, 1'b0, 1'b0);
        step("fill3", 1'b1, 32'h208, 32'h0020_0193, 1'b0, 1'b0);
        check("fill3.head", dec_pc_out, 32'h200);
        check("fill3.count", 32'(count_out), 32'd2);

        // Full with enqueue and dequeue together: only the dequeue happens.
        step("full_both", 1'b1, 32'h208, 32'h0020_0193, 1'b1, 1'b0);
        check("full_both.count", 32'(count_out), 32'd1);
        step("both", 1'b1, 32'h208, 32'h0020_0193, 1'b1, 1'b0);
        check("both.head", dec_pc_out, 32'h208);
        step("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush while full, with an enqueue in the same cycle.
        step("pref1", 1'b1, 32'h300, 32'h0000_0033, 1'b0, 1'b0);
        step("pref2", 1'b1, 32'h304, 32'h0000_0037, 1'b0, 1'b0);
        step("flush", 1'b1, 32'h308, 32'h0000_003B, 1'b1, 1'b1);
        check("flush.count", 32'(count_out), 32'd0);

        // Illegal encoding.
        step("illegal", 1'b1, 32'h400, 32'h0000_0000, 1'b0, 1'b0);
        check("illegal.flag", 32'(dec_illegal_out), 32'd1);
        step("illegal.drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Random stream of 10 instructions; the pointers wrap several times.
        sent    = 0;
        cycles  = 0;
        drained = 0;
        while ((sent < 10 || model_q.size() != 0) && cycles < 300) begin
            logic fv;
            fv    = (sent < 10) && ($urandom_range(0, 3) != 0);
            rinst = (sent == 5) ? 32'h0 : $urandom;
            if (fv && model_q.size() < DEPTH) sent++;
            step("rand", fv, 32'h1000 + 32'(sent) * 4, rinst, 1'($urandom_range(0, 1)), 1'b0);
            cycles++;
        end
        check("rand.sent", 32'(sent), 32'd10);
        check("rand.drained", 32'(drained), 32'd10);

        // Asynchronous reset between edges with one entry buffered.
        step("pre_reset", 1'b1, 32'h500, 32'h0000_0093, 1'b0, 1'b0);
        fetch_valid_in = 1'b0;
        #2;
        reset_in = 1'b1;
        #1;
        model_q.delete();
        check_model("async_reset");
        @(negedge clock_in);
        reset_in = 1'b0;

        // The first edge after reset accepts an enqueue normally.
        step("post_reset", 1'b1, 32'h600, 32'h0000_0113, 1'b0, 1'b0);
        check("post_reset.pc", dec_pc_out, 32'h600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
